// File: rtl/flag_cond_unit.sv
// Architectural N/Z/C/V flag register, in-flight flag-writer tracking and
// one-cycle branch-condition resolution. Define FLAG_BYPASS_EN to forward EX flags.
module flag_cond_unit #(
  parameter int MAX_PEND = 3,
  parameter int COND_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_set,
  input  logic              flag_we,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_v,
  input  logic              alu_c,
  input  logic              flush,
  input  logic              br_valid,
  input  logic [COND_W-1:0] br_cond,
  output logic              br_ready,
  output logic              resp_valid,
  output logic              resp_taken,
  output logic [3:0]        flags,
  output logic              pend_full,
  output logic              pend_err
);

  localparam int CNT_W = $clog2(MAX_PEND + 1);
  localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(MAX_PEND);
  localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_pend;
  logic [3:0]       r_flags;
  logic             r_resp_valid;
  logic             r_resp_taken;
  logic             r_err;

  logic [3:0]       w_alu_flags;
  logic [3:0]       w_eval_flags;
  logic             w_accept;
  logic             w_taken;

  // Flag vector ordering is {N,Z,C,V}
  function automatic logic f_eval(input logic [3:0] code, input logic [3:0] f);
    logic n, z, c, v, res;
    {n, z, c, v} = f;
    case (code)
      4'h0:    res = z;
      4'h1:    res = ~z;
      4'h2:    res = c;
      4'h3:    res = ~c;
      4'h4:    res = n;
      4'h5:    res = ~n;
      4'h6:    res = v;
      4'h7:    res = ~v;
      4'h8:    res = c & ~z;
      4'h9:    res = ~c | z;
      4'hA:    res = (n == v);
      4'hB:    res = (n != v);
      4'hC:    res = ~z & (n == v);
      4'hD:    res = z | (n != v);
      4'hE:    res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  assign w_alu_flags = {alu_n, alu_z, alu_c, alu_v};

`ifdef FLAG_BYPASS_EN
  logic w_bypass;
  // The only outstanding writer retires this cycle, so its flags are forwarded
  assign w_bypass     = (r_pend == PEND_ONE) & flag_we & ~issue_set;
  assign br_ready     = ((r_pend == '0) | w_bypass) & ~flush;
  assign w_eval_flags = w_bypass ? w_alu_flags : r_flags;
`else
  assign br_ready     = (r_pend == '0) & ~flush;
  assign w_eval_flags = r_flags;
`endif

  assign w_accept = br_valid & br_ready;
  assign w_taken  = f_eval(br_cond[3:0], w_eval_flags);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend       <= '0;
      r_flags      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_taken <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      if (flag_we) begin
        r_flags <= w_alu_flags;
      end

      r_resp_valid <= w_accept;
      if (w_accept) begin
        r_resp_taken <= w_taken;
      end

      if (flush) begin
        r_pend <= '0;
      end else if (issue_set && !flag_we) begin
        if (r_pend == PEND_MAX) r_err  <= 1'b1;
        else                    r_pend <= r_pend + 1'b1;
      end else if (flag_we && !issue_set) begin
        if (r_pend == '0) r_err  <= 1'b1;
        else              r_pend <= r_pend - 1'b1;
      end
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_taken = r_resp_taken;
  assign flags      = r_flags;
  assign pend_full  = (r_pend == PEND_MAX);
  assign pend_err   = r_err;

endmodule
